eth_rx_ctrl: RTL and testbench
==============================

Name: eth_rx_ctrl

Overview:
- Receive-side controller between the SPI frame deserializer and the shared receive frame buffer of the ethernet receiver system.
- Manages two frame slots in ping-pong fashion and applies the destination-MAC filter.
- Decides commit or discard per frame, records frame length, and exposes slot status and length to the CPU register interface (CR recv-full bit, RECV_LEN lo/hi).

Parameters:
- MAC, 48'hFAFAF6F2EEEA: own station address; byte 0 on the wire is MAC[47:40].
- ADDR_W, 11: per-slot buffer offset width; slot capacity is 2^ADDR_W bytes.
- MIN_LEN, 14: minimum accepted frame length in bytes.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_sof  in  1  one-cycle pulse, frame start (SS asserted)
- rx_byte_valid  in  1  one-cycle pulse, rx_byte holds a received byte
- rx_byte  in  8  received byte, first wire byte first
- rx_eof  in  1  one-cycle pulse, frame end (SS deasserted)
- promisc  in  1  1 = accept any destination MAC
- release  in  1  one-cycle pulse, CPU frees the current read slot (CR write)
- buf_we  out  1  frame buffer write enable
- buf_waddr  out  ADDR_W+1  {slot, offset} write address
- buf_wdata  out  8  write data
- rd_slot  out  1  slot the CPU reads; MSB of CPU-side buffer address
- recv_full  out  1  CR bit 0: rd_slot holds a committed frame
- recv_len  out  16  committed length of rd_slot, zero-extended
- drop_cnt  out  8  saturating count of frames lost to runt, oversize or no free slot

Behaviour:
- Reset (async, n_rst=0): state IDLE; wr_slot=0; rd_slot=0; full[1:0]=0; both lengths=0; byte counter=0; drop_cnt=0; buf_we=0; buf_waddr=0; buf_wdata=0.
- Registered outputs: buf_we/waddr/wdata are valid the cycle after rx_byte_valid. recv_full and recv_len follow full[rd_slot] and len[rd_slot] combinationally.
- FSM states: IDLE, HDR, BODY, DROP, SKIP.
- IDLE + rx_sof:
  - full[wr_slot]=0 -> HDR, counter=0, match flags set.
  - full[wr_slot]=1 -> DROP.
- HDR:
  - Each byte is written to {wr_slot, counter}, then counter+1.
  - Byte i is compared against MAC byte i and against 8'hFF; two sticky flags, own and broadcast.
  - After byte 5: own|bcast|promisc -> BODY, else -> SKIP.
- BODY: each byte is written and counter+1.
  - A byte arriving when counter==2^ADDR_W -> DROP, no write.
- rx_eof in BODY:
  - counter>=MIN_LEN: len[wr_slot]=counter, full[wr_slot]=1, wr_slot toggles, -> IDLE.
  - Otherwise -> IDLE, drop.
- rx_eof in HDR (runt): -> IDLE, drop.
- rx_eof in DROP: -> IDLE, drop. In SKIP: -> IDLE, no drop.
- DROP/SKIP: no writes. Further bytes are ignored.
- Drop action: drop_cnt+1, saturating at 255. MAC-filtered frames (SKIP) are never counted.
- rx_sof in any non-IDLE state: the current frame is abandoned uncounted, then handled exactly as rx_sof in IDLE. Partially written slot data is simply overwritten later.
- rx_byte_valid and rx_eof in the same cycle: the byte is processed first, then eof.
- release:
  - With recv_full=1: full[rd_slot]=0, rd_slot toggles.
  - With recv_full=0: ignored.
- Commit and release in the same cycle: both take effect. They always target different slots, because the commit slot is free.
- Slot order is FIFO: rd_slot always points at the oldest committed frame.
- A frame is never visible (recv_full) before its commit cycle. Slot data is never written while its full bit is 1.

Test Plan:
- After reset: recv_full=0, recv_len=0, drop_cnt=0, rd_slot=0.
- Frame FA FA F6 F2 EE EA, then 14 bytes -> buf_waddr 0x000..0x013 written; on eof recv_full=1, recv_len=20, wr_slot=1.
- Dest FA FA F5 F4 EB EA, then AA 55 73 87, promisc=0 -> no writes after byte 5, recv_full stays 0, drop_cnt=0. Same frame with promisc=1 -> 10 bytes, below MIN_LEN: drop_cnt=1, recv_full=0.
- Broadcast FF×6 + 10 bytes -> accepted, recv_len=16.
- Three valid frames of 20, 30 and 40 bytes with no release -> first two committed; third: no writes, drop_cnt=1. release -> recv_len=30, rd_slot=1. release -> recv_full=0.
- Frame of 2049 bytes (ADDR_W=11) -> writes stop at offset 0x7FF, drop_cnt+1, recv_full=0. rx_sof after byte 3 of a good frame, then a full 20-byte frame -> only the second frame committed, drop_cnt unchanged. n_rst pulse mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/eth_rx_ctrl.sv
// eth_rx_ctrl: receive-side controller between the SPI frame deserializer
// and the two-slot receive frame buffer. Writes incoming bytes into the
// free slot, filters on destination MAC, commits or discards each frame,
// and presents the oldest committed frame (slot, length) to the CPU side.
module eth_rx_ctrl #(
  parameter logic [47:0] MAC     = 48'hFAFAF6F2EEEA,
  parameter int          ADDR_W  = 11,
  parameter int          MIN_LEN = 14
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rx_sof,
  input  logic              rx_byte_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_eof,
  input  logic              promisc,
  input  logic              release_req,
  output logic              buf_we,
  output logic [ADDR_W:0]   buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic              rd_slot,
  output logic              recv_full,
  output logic [15:0]       recv_len,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    DROP,
    SKIP
  } state_t;

  // Counter value that marks a completely filled slot; a byte arriving here overflows.
  localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] MIN_L    = (ADDR_W + 1)'(MIN_LEN);
  localparam logic [ADDR_W:0] LAST_HDR = (ADDR_W + 1)'(5);

  state_t            state_q, state_d;
  logic              wr_slot_q, wr_slot_d;
  logic              rd_slot_q, rd_slot_d;
  logic [1:0]        full_q, full_d;
  logic [ADDR_W:0]   len0_q, len0_d;
  logic [ADDR_W:0]   len1_q, len1_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              own_q, own_d;
  logic              bcast_q, bcast_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W:0]   buf_waddr_q, buf_waddr_d;
  logic [7:0]        buf_wdata_q, buf_wdata_d;
  logic              do_drop;
  logic              do_commit;

  // Own-address byte expected at header position idx (wire order, MSB first).
  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return MAC[47:40];
      3'd1:    return MAC[39:32];
      3'd2:    return MAC[31:24];
      3'd3:    return MAC[23:16];
      3'd4:    return MAC[15:8];
      3'd5:    return MAC[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Next-state logic: frame tracking (byte before eof), commit/drop, CPU release.
  always_comb begin
    state_d     = state_q;
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    full_d      = full_q;
    len0_d      = len0_q;
    len1_d      = len1_q;
    cnt_d       = cnt_q;
    own_d       = own_q;
    bcast_d     = bcast_q;
    drop_cnt_d  = drop_cnt_q;
    buf_we_d    = 1'b0;
    buf_waddr_d = buf_waddr_q;
    buf_wdata_d = buf_wdata_q;
    do_drop     = 1'b0;
    do_commit   = 1'b0;

    if (rx_sof) begin
      cnt_d   = '0;
      own_d   = 1'b1;
      bcast_d = 1'b1;
      state_d = full_q[wr_slot_q] ? DROP : HDR;
    end else begin
      case (state_q)
        HDR: begin
          if (rx_byte_valid) begin
            buf_we_d    = 1'b1;
            buf_waddr_d = {wr_slot_q, cnt_q[ADDR_W-1:0]};
            buf_wdata_d = rx_byte;
            own_d       = own_q & (rx_byte == mac_byte(cnt_q[2:0]));
            bcast_d     = bcast_q & (rx_byte == 8'hFF);
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == LAST_HDR) begin
              state_d = (own_d | bcast_d | promisc) ? BODY : SKIP;
            end
          end
        end
        BODY: begin
          if (rx_byte_valid) begin
            if (cnt_q == CAP) begin
              state_d = DROP;
            end else begin
              buf_we_d    = 1'b1;
              buf_waddr_d = {wr_slot_q, cnt_q[ADDR_W-1:0]};
              buf_wdata_d = rx_byte;
              cnt_d       = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (rx_eof) begin
        case (state_d)
          HDR: begin
            do_drop = 1'b1;
            state_d = IDLE;
          end
          BODY: begin
            if (cnt_d >= MIN_L) begin
              do_commit = 1'b1;
            end else begin
              do_drop = 1'b1;
            end
            state_d = IDLE;
          end
          DROP: begin
            do_drop = 1'b1;
            state_d = IDLE;
          end
          SKIP: state_d = IDLE;
          default: ;
        endcase
      end
    end

    if (do_commit) begin
      full_d[wr_slot_q] = 1'b1;
      if (wr_slot_q) begin
        len1_d = cnt_d;
      end else begin
        len0_d = cnt_d;
      end
      wr_slot_d = ~wr_slot_q;
    end

    if (release_req && full_q[rd_slot_q]) begin
      full_d[rd_slot_q] = 1'b0;
      rd_slot_d         = ~rd_slot_q;
    end

    if (do_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      wr_slot_q   <= 1'b0;
      rd_slot_q   <= 1'b0;
      full_q      <= 2'b00;
      len0_q      <= '0;
      len1_q      <= '0;
      cnt_q       <= '0;
      own_q       <= 1'b0;
      bcast_q     <= 1'b0;
      drop_cnt_q  <= 8'd0;
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      full_q      <= full_d;
      len0_q      <= len0_d;
      len1_q      <= len1_d;
      cnt_q       <= cnt_d;
      own_q       <= own_d;
      bcast_q     <= bcast_d;
      drop_cnt_q  <= drop_cnt_d;
      buf_we_q    <= buf_we_d;
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
    end
  end

  assign buf_we    = buf_we_q;
  assign buf_waddr = buf_waddr_q;
  assign buf_wdata = buf_wdata_q;
  assign rd_slot   = rd_slot_q;
  assign drop_cnt  = drop_cnt_q;
  assign recv_full = full_q[rd_slot_q];
  assign recv_len  = {{(15 - ADDR_W){1'b0}}, (rd_slot_q ? len1_q : len0_q)};

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb_eth_rx_ctrl: table-driven frame scenarios, hand-written corner
// sequences and randomized traffic, all checked against a frame-level
// reference model of the receive controller.
module tb_eth_rx_ctrl;

  localparam logic [47:0] MAC     = 48'hFAFAF6F2EEEA;
  localparam logic [47:0] OTHER   = 48'hFAFAF5F4EBEA;
  localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;
  localparam int          ADDR_W  = 11;
  localparam int          CAP     = 2048;
  localparam int          MIN_LEN = 14;

  logic              clk;
  logic              n_rst;
  logic              rxSof;
  logic              rxByteValid;
  logic [7:0]        rxByte;
  logic              rxEof;
  logic              promisc;
  logic              releaseReq;
  logic              buf_we;
  logic [ADDR_W:0]   buf_waddr;
  logic [7:0]        buf_wdata;
  logic              rd_slot;
  logic              recv_full;
  logic [15:0]       recv_len;
  logic [7:0]        drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: slot occupancy and the frame currently being received.
  bit          mFull[2];
  int          mLen[2];
  bit          mWr;
  bit          mRd;
  int          mDrop;
  bit          mActive;
  bit          mHasSlot;
  bit          mPass;
  int          mCount;
  logic [47:0] mDest;
  bit          eWe;
  int          eAddr;
  logic [7:0]  eData;

  typedef struct {
    int          op;
    logic [47:0] dest;
    int          len;
    bit          pr;
    bit          expFull;
    int          expLen;
    int          expDrop;
    bit          expRd;
  } vec_t;

  vec_t vecs[16];

  eth_rx_ctrl #(.MAC(MAC), .ADDR_W(ADDR_W), .MIN_LEN(MIN_LEN)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_sof       (rxSof),
    .rx_byte_valid(rxByteValid),
    .rx_byte      (rxByte),
    .rx_eof       (rxEof),
    .promisc      (promisc),
    .release_req  (releaseReq),
    .buf_we       (buf_we),
    .buf_waddr    (buf_waddr),
    .buf_wdata    (buf_wdata),
    .rd_slot      (rd_slot),
    .recv_full    (recv_full),
    .recv_len     (recv_len),
    .drop_cnt     (drop_cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mFull[0] = 0; mFull[1] = 0;
    mLen[0]  = 0; mLen[1]  = 0;
    mWr = 0; mRd = 0; mDrop = 0;
    mActive = 0; mHasSlot = 0; mPass = 0; mCount = 0; mDest = '0;
    eWe = 0; eAddr = 0; eData = 8'h00;
  endtask

  task automatic countDrop();
    if (mDrop < 255) mDrop++;
  endtask

  // Frame-level rules: a byte is stored only while the slot is usable and the
  // header is unresolved or accepted; the verdict comes from the final length.
  task automatic modelCycle(input bit sof, input bit valid, input logic [7:0] b,
                            input bit eof, input bit rel, input bit pr);
    bit preFullRd;
    int pos;
    preFullRd = mFull[mRd];
    eWe = 0;
    if (sof) begin
      mActive  = 1;
      mHasSlot = !mFull[mWr];
      mCount   = 0;
      mPass    = 0;
      mDest    = '0;
    end else begin
      if (valid && mActive) begin
        pos = mCount;
        if (pos < 6) mDest[47 - 8*pos -: 8] = b;
        if (pos == 5) mPass = (mDest == MAC) || (mDest == BCAST) || pr;
        if (mHasSlot && (pos < 6 || (mPass && pos < CAP))) begin
          eWe   = 1;
          eAddr = (int'(mWr) << ADDR_W) + pos;
          eData = b;
        end
        mCount++;
      end
      if (eof && mActive) begin
        mActive = 0;
        if (!mHasSlot || mCount < 6) countDrop();
        else if (!mPass) ;
        else if (mCount > CAP || mCount < MIN_LEN) countDrop();
        else begin
          mFull[mWr] = 1;
          mLen[mWr]  = mCount;
          mWr        = !mWr;
        end
      end
    end
    if (rel && preFullRd) begin
      mFull[mRd] = 0;
      mRd        = !mRd;
    end
  endtask

  task automatic compareAll();
    checkOutput("buf_we", buf_we, eWe);
    if (eWe) begin
      checkOutput("buf_waddr", buf_waddr, eAddr);
      checkOutput("buf_wdata", buf_wdata, eData);
    end
    checkOutput("recv_full", recv_full, mFull[mRd]);
    checkOutput("recv_len", recv_len, mLen[mRd]);
    checkOutput("rd_slot", rd_slot, mRd);
    checkOutput("drop_cnt", drop_cnt, mDrop);
  endtask

  // One clock cycle: drive inputs, sample 1 unit after the edge, check against the model.
  task automatic applyStimulus(input bit sof, input bit valid, input logic [7:0] b,
                               input bit eof, input bit rel);
    rxSof       = sof;
    rxByteValid = valid;
    rxByte      = b;
    rxEof       = eof;
    releaseReq  = rel;
    @(posedge clk);
    #1;
    modelCycle(sof, valid, b, eof, rel, promisc);
    compareAll();
  endtask

  task automatic idle(input int n, input bit randRel);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 8'h00, 0, randRel && ($urandom_range(0, 3) == 0));
  endtask

  task automatic partialFrame(input logic [47:0] dest, input int k);
    applyStimulus(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < k; i++)
      applyStimulus(0, 1, (i < 6) ? dest[47 - 8*i -: 8] : 8'($urandom), 0, 0);
  endtask

  task automatic sendFrame(input logic [47:0] dest, input int n, input bit eofWithLast,
                           input bit randRel);
    logic [7:0] b;
    bit         last;
    applyStimulus(1, 0, 8'h00, 0, randRel && ($urandom_range(0, 7) == 0));
    for (int i = 0; i < n; i++) begin
      b    = (i < 6) ? dest[47 - 8*i -: 8] : 8'($urandom);
      last = (i == n - 1);
      applyStimulus(0, 1, b, last && eofWithLast, randRel && ($urandom_range(0, 7) == 0));
    end
    if (!eofWithLast || n == 0)
      applyStimulus(0, 0, 8'h00, 1, randRel && ($urandom_range(0, 7) == 0));
    applyStimulus(0, 0, 8'h00, 0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " buf_we"}, buf_we, 0);
    checkOutput({tag, " buf_waddr"}, buf_waddr, 0);
    checkOutput({tag, " buf_wdata"}, buf_wdata, 0);
    checkOutput({tag, " recv_full"}, recv_full, 0);
    checkOutput({tag, " recv_len"}, recv_len, 0);
    checkOutput({tag, " drop_cnt"}, drop_cnt, 0);
    checkOutput({tag, " rd_slot"}, rd_slot, 0);
  endtask

  task automatic checkState(input string tag, input bit f, input int l, input int d, input bit r);
    checkOutput({tag, " recv_full"}, recv_full, f);
    checkOutput({tag, " recv_len"}, recv_len, l);
    checkOutput({tag, " drop_cnt"}, drop_cnt, d);
    checkOutput({tag, " rd_slot"}, rd_slot, r);
  endtask

  initial begin
    logic [47:0] dest;
    int          n;
    int          r;

    // op 0 = frame, op 1 = CPU release; expected status after each step.
    vecs[0]  = '{0, MAC,   20,   0, 1, 20,   0, 0};
    vecs[1]  = '{0, OTHER, 10,   0, 1, 20,   0, 0};
    vecs[2]  = '{0, OTHER, 10,   1, 1, 20,   1, 0};
    vecs[3]  = '{1, '0,    0,    0, 0, 0,    1, 1};
    vecs[4]  = '{0, BCAST, 16,   0, 1, 16,   1, 1};
    vecs[5]  = '{0, MAC,   20,   0, 1, 16,   1, 1};
    vecs[6]  = '{0, MAC,   40,   0, 1, 16,   2, 1};
    vecs[7]  = '{1, '0,    0,    0, 1, 20,   2, 0};
    vecs[8]  = '{1, '0,    0,    0, 0, 16,   2, 1};
    vecs[9]  = '{0, MAC,   2049, 0, 0, 16,   3, 1};
    vecs[10] = '{0, MAC,   2048, 0, 1, 2048, 3, 1};
    vecs[11] = '{0, MAC,   14,   0, 1, 2048, 3, 1};
    vecs[12] = '{1, '0,    0,    0, 1, 14,   3, 0};
    vecs[13] = '{0, MAC,   13,   0, 1, 14,   4, 0};
    vecs[14] = '{0, MAC,   4,    0, 1, 14,   5, 0};
    vecs[15] = '{0, MAC,   6,    0, 1, 14,   6, 0};

    n_rst = 1'b0; rxSof = 0; rxByteValid = 0; rxByte = 8'h00; rxEof = 0;
    promisc = 0; releaseReq = 0;
    modelReset();
    #12;
    checkResetOutputs("reset");
    #1 n_rst = 1'b1;
    idle(2, 0);

    for (int i = 0; i < 16; i++) begin
      promisc = vecs[i].pr;
      if (vecs[i].op == 0) sendFrame(vecs[i].dest, vecs[i].len, bit'(i % 2), 0);
      else applyStimulus(0, 0, 8'h00, 0, 1);
      idle(1, 0);
      checkState($sformatf("vec%0d", i), vecs[i].expFull, vecs[i].expLen,
                 vecs[i].expDrop, vecs[i].expRd);
    end
    promisc = 0;

    // Restart after three header bytes: only the second frame lands, no drop counted.
    partialFrame(MAC, 3);
    sendFrame(MAC, 20, 0, 0);
    checkState("abort", 1, 14, 6, 0);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkState("abort rel", 1, 20, 6, 1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkState("abort rel2", 0, 14, 6, 0);

    // Commit and release in the same cycle, last byte sharing the eof cycle.
    sendFrame(MAC, 20, 1, 0);
    checkState("pre both", 1, 20, 6, 0);
    partialFrame(MAC, 30);
    applyStimulus(0, 0, 8'h00, 1, 1);
    idle(1, 0);
    checkState("commit+rel", 1, 30, 6, 1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    idle(1, 0);

    // Drop counter saturation with repeated header runts.
    for (int i = 0; i < 252; i++) sendFrame(MAC, 3, 0, 0);
    checkOutput("drop_sat", drop_cnt, 255);

    // Asynchronous reset in the middle of a frame.
    partialFrame(MAC, 8);
    n_rst = 1'b0;
    #1;
    checkResetOutputs("midreset");
    modelReset();
    #3 n_rst = 1'b1;
    idle(2, 0);

    // Randomized traffic with random releases, aborts and promiscuous mode.
    for (int f = 0; f < 400; f++) begin
      promisc = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: dest = MAC;
        1: dest = BCAST;
        2: dest = OTHER;
        3: dest = {$urandom, $urandom};
        default: begin
          dest = MAC;
          dest[8*$urandom_range(0, 5) +: 8] ^= 8'h01;
        end
      endcase
      r = $urandom_range(0, 19);
      if (r < 3) n = $urandom_range(0, 6);
      else if (r < 16) n = $urandom_range(7, 60);
      else if (r == 19 && $urandom_range(0, 3) == 0) n = $urandom_range(2044, 2052);
      else n = $urandom_range(13, 20);
      if ($urandom_range(0, 15) == 0) partialFrame(dest, $urandom_range(0, 10));
      sendFrame(dest, n, bit'($urandom_range(0, 1)), 1);
      idle($urandom_range(0, 3), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
